// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the ram arbiter slice
//   state_t : arbiter FSM encoding (IDLE, ACC, ACK)
//   P0/P1   : requester port indices
//   Log()   : address width for a word count, never less than 1
package ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    function automatic int Log(input int n);
        int g = 1;
        while ((1 << g) < n) g++;
        return g;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: one requester's Req/Ack command channel
//   req, we, a, d : command from requester (held until ack)
//   ack           : one-cycle completion pulse
//   q             : read data, valid with ack, held until the next read
//   master = requester side, slave = arbiter side
interface ram_arbiter_if #(
    parameter int G = 3,
    parameter int W = 4
);
    logic         req;
    logic         we;
    logic [G-1:0] a;
    logic [W-1:0] d;
    logic         ack;
    logic [W-1:0] q;

    modport master (output req, we, a, d, input ack, q);
    modport slave  (input req, we, a, d, output ack, q);
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// rr_pick: combinational winner selection between two requesters
//   i_req[1:0] : request lines of ports 1 and 0
//   i_last     : port granted last time (round-robin pointer)
//   o_gnt      : winning port index
//   RAM_ARB_FIXED_PRI_EN defined -> port 0 always wins a tie, i_last ignored
module rr_pick
    import ram_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_gnt
);

`ifdef RAM_ARB_FIXED_PRI_EN
    assign o_gnt = i_req[0] ? P0 : P1;
`else
    // Tie goes to the port that did not win last; otherwise the lone requester.
    assign o_gnt = (&i_req) ? ~i_last : (i_req[1] ? P1 : P0);
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port Req/Ack arbiter sequencing a single-port register file
//   C          : clock, rising edge
//   nR         : synchronous active-low reset
//   p0, p1     : requester channels (ram_arbiter_if.slave)
//   o_ram_wr   : ram write enable, only in ACC
//   o_ram_a    : ram address (holds last access value)
//   o_ram_d    : ram write data (holds last access value)
//   i_ram_q    : ram combinational read data
//   RAM_ARB_FIXED_PRI_EN defined -> fixed priority to port 0, else round-robin
module ram_arbiter
    import ram_pkg::*;
#(
    parameter  int N = 8,
    parameter  int W = 4,
    localparam int G = Log(N)
) (
    input  logic           C,
    input  logic           nR,
    ram_arbiter_if.slave   p0,
    ram_arbiter_if.slave   p1,
    output logic           o_ram_wr,
    output logic [G-1:0]   o_ram_a,
    output logic [W-1:0]   o_ram_d,
    input  logic [W-1:0]   i_ram_q
);

    localparam logic [G:0] NL = (G+1)'(N);

    state_t       r_state;
    logic         r_gnt;
    logic         r_last;
    logic         r_we;
    logic [G-1:0] r_a;
    logic [W-1:0] r_d;
    logic [W-1:0] r_q0;
    logic [W-1:0] r_q1;
    logic         r_ack0;
    logic         r_ack1;
    logic         w_gnt;
    logic         w_ok;

    rr_pick u_pick (
        .i_req  ({p1.req, p0.req}),
        .i_last (r_last),
        .o_gnt  (w_gnt)
    );

    // Out-of-range words (non-power-of-2 N) are never written and read as 0.
    assign w_ok     = {1'b0, r_a} < NL;
    assign o_ram_a  = r_a;
    assign o_ram_d  = r_d;
    // nR gates the strobe directly so a reset during ACC suppresses the write.
    assign o_ram_wr = (r_state == ACC) & r_we & w_ok & nR;
    assign p0.ack   = r_ack0;
    assign p1.ack   = r_ack1;
    assign p0.q     = r_q0;
    assign p1.q     = r_q1;

    always_ff @(posedge C) begin
        if (!nR) begin
            r_state <= IDLE;
            r_gnt   <= P0;
            r_last  <= P1;
            r_we    <= 1'b0;
            r_a     <= '0;
            r_d     <= '0;
            r_q0    <= '0;
            r_q1    <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (p0.req | p1.req) begin
                    r_gnt   <= w_gnt;
                    r_we    <= w_gnt ? p1.we : p0.we;
                    r_a     <= w_gnt ? p1.a  : p0.a;
                    r_d     <= w_gnt ? p1.d  : p0.d;
                    r_state <= ACC;
                end
                ACC: begin
                    if (!r_we && r_gnt)  r_q1 <= w_ok ? i_ram_q : '0;
                    if (!r_we && !r_gnt) r_q0 <= w_ok ? i_ram_q : '0;
                    r_ack0  <= ~r_gnt;
                    r_ack1  <= r_gnt;
                    r_state <= ACK;
                end
                ACK: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_last  <= r_gnt;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with a behavioural register file
module tb_ram_arbiter;
    import ram_pkg::*;

    localparam int N = 8;
    localparam int W = 4;
    localparam int G = Log(N);

    typedef struct {
        int           port;
        bit           rd;
        logic [W-1:0] q;
    } exp_t;

    logic         C = 1'b0;
    logic         nR = 1'b0;
    logic         ram_wr;
    logic [G-1:0] ram_a;
    logic [W-1:0] ram_d;
    logic [W-1:0] ram_q;
    logic [W-1:0] mem   [N];
    logic [W-1:0] model [N];
    exp_t         sb [$];
    exp_t         mon_e;
    int           errors = 0;
    int           checks = 0;
    int           ack0_cnt = 0;
    int           ack1_cnt = 0;
    int           wr_cnt = 0;

    ram_arbiter_if #(.G(G), .W(W)) p0 ();
    ram_arbiter_if #(.G(G), .W(W)) p1 ();

    ram_arbiter #(.N(N), .W(W)) dut (
        .C        (C),
        .nR       (nR),
        .p0       (p0),
        .p1       (p1),
        .o_ram_wr (ram_wr),
        .o_ram_a  (ram_a),
        .o_ram_d  (ram_d),
        .i_ram_q  (ram_q)
    );

    always #5 C = ~C;

    always @(posedge C) if (ram_wr) mem[ram_a] <= ram_d;
    assign ram_q = mem[ram_a];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void expect_op(input int p, input bit we, input int a, input int d);
        if (we) model[a] = W'(d);
        sb.push_back('{p, !we, model[a]});
    endfunction

    always @(negedge C) begin
        if (ram_wr) wr_cnt++;
        if (p0.ack) ack0_cnt++;
        if (p1.ack) ack1_cnt++;
        if (p0.ack || p1.ack) begin
            check("single_ack", p0.ack & p1.ack, 0);
            if (sb.size() == 0) begin
                check("spurious_ack", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("ack_port", p1.ack, mon_e.port);
                if (mon_e.rd) check("rd_q", mon_e.port == 1 ? p1.q : p0.q, mon_e.q);
            end
        end
    end

    task automatic drive(input int p, input bit r, input bit we, input int a, input int d);
        if (p == 1) begin
            p1.req = r; p1.we = we; p1.a = G'(a); p1.d = W'(d);
        end else begin
            p0.req = r; p0.we = we; p0.a = G'(a); p0.d = W'(d);
        end
    endtask

    // Raise a request, wait for its Ack (bounded), drop it; gap adds one idle cycle.
    task automatic xact(input int p, input bit we, input int a, input int d, input int lat, input bit gap);
        int n = 0;
        drive(p, 1'b1, we, a, d);
        do begin
            @(negedge C);
            n++;
        end while (!(p == 1 ? p1.ack : p0.ack) && n < 20);
        if (n >= 20) check("ack_timeout", 0, 1);
        else if (lat >= 0) check("latency", n, lat);
        drive(p, 1'b0, we, a, d);
        if (gap) @(negedge C);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int acks;
        int n;
        int a1_before;
        int a0_before;
        logic [W-1:0] q1_prev;
        for (int i = 0; i < N; i++) begin
            mem[i]   = '0;
            model[i] = '0;
        end
        drive(0, 1'b0, 1'b0, 0, 0);
        drive(1, 1'b0, 1'b0, 0, 0);

        // Reset held two cycles with a pending request
        @(negedge C);
        drive(0, 1'b1, 1'b0, 0, 0);
        expect_op(0, 0, 0, 0);
        repeat (2) begin
            @(negedge C);
            check("rst_ack0", p0.ack, 0);
            check("rst_ack1", p1.ack, 0);
            check("rst_q0", p0.q, 0);
            check("rst_q1", p1.q, 0);
            check("rst_wr", ram_wr, 0);
        end
        nR = 1'b1;
        xact(0, 0, 0, 0, 2, 1);

        // Single write then read on port 0
        wr_cnt = 0;
        expect_op(0, 1, 3, 'hA);
        xact(0, 1, 3, 'hA, 2, 1);
        check("wr_cycles", wr_cnt, 1);
        wr_cnt = 0;
        expect_op(0, 0, 3, 0);
        xact(0, 0, 3, 0, 2, 1);
        check("rd_wr_cycles", wr_cnt, 0);
        check("ram_a_hold", ram_a, 3);
        check("q0_read", p0.q, 'hA);

        // Contention: set pointer to port 1 first, then hold both requests
        expect_op(1, 0, 1, 0);
        xact(1, 0, 1, 0, 2, 1);
        a1_before = ack1_cnt;
`ifdef RAM_ARB_FIXED_PRI_EN
        for (int i = 0; i < 4; i++) expect_op(0, 0, 3, 0);
`else
        for (int i = 0; i < 4; i++) expect_op(i % 2, 0, (i % 2) ? 1 : 3, 0);
`endif
        drive(0, 1'b1, 1'b0, 3, 0);
        drive(1, 1'b1, 1'b0, 1, 0);
        acks = 0;
        n = 0;
        while (acks < 4 && n < 60) begin
            @(negedge C);
            n++;
            if (p0.ack || p1.ack) acks++;
        end
        drive(0, 1'b0, 1'b0, 3, 0);
        drive(1, 1'b0, 1'b0, 1, 0);
        @(negedge C);
        check("cont_acks", acks, 4);
`ifdef RAM_ARB_FIXED_PRI_EN
        check("cont_ack1", ack1_cnt - a1_before, 0);
        expect_op(1, 0, 1, 0);
        xact(1, 0, 1, 0, 2, 1);
`else
        check("cont_ack1", ack1_cnt - a1_before, 2);
`endif

        // Isolation: port 1 write races port 0 read of the same word
        expect_op(0, 0, 5, 0);
        xact(0, 0, 5, 0, 2, 1);
        q1_prev = p1.q;
`ifdef RAM_ARB_FIXED_PRI_EN
        expect_op(0, 0, 5, 0);
        expect_op(1, 1, 5, 6);
`else
        expect_op(1, 1, 5, 6);
        expect_op(0, 0, 5, 0);
`endif
        fork
            xact(1, 1, 5, 6, -1, 1);
            xact(0, 0, 5, 0, -1, 1);
        join
        check("iso_q1", p1.q, q1_prev);
`ifdef RAM_ARB_FIXED_PRI_EN
        check("iso_q0", p0.q, 0);
`else
        check("iso_q0", p0.q, 6);
`endif

        // Abort: reset lands during ACC of a write
        a0_before = ack0_cnt;
        drive(0, 1'b1, 1'b1, 2, 'hF);
        @(negedge C);
        check("abort_acc_wr", ram_wr, 1);
        nR = 1'b0;
        #1;
        check("abort_wr_off", ram_wr, 0);
        drive(0, 1'b0, 1'b0, 2, 0);
        @(negedge C);
        nR = 1'b1;
        repeat (3) @(negedge C);
        check("abort_no_ack", ack0_cnt - a0_before, 0);
        expect_op(0, 0, 2, 0);
        xact(0, 0, 2, 0, 2, 1);

        // Back-to-back writes on port 1 with Req held, then read-back
        for (int i = 0; i < 3; i++) begin
            expect_op(1, 1, i, i + 1);
            xact(1, 1, i, i + 1, i == 0 ? 2 : 3, 0);
        end
        for (int i = 0; i < 3; i++) begin
            expect_op(1, 0, i, 0);
            xact(1, 0, i, 0, 3, i == 2);
        end
        check("b2b_q1", p1.q, 3);

        repeat (3) @(negedge C);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
